// File: rtl/wavegen_pkg.sv
// Shared definitions for the wave datapath controller: register map, control bits,
// sequencer states and channel widths.
package wavegen_pkg;

  localparam int CH_W   = 32;
  localparam int DIV_W  = 16;
  localparam int ADDR_W = 3;
  localparam int ERR_W  = 2;

  localparam logic [ADDR_W-1:0] ADDR_AMPS    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OFFSETS = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PHASE   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_DIV     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd4;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_COMMIT  = 1;
  localparam int CTRL_RESYNC  = 2;
  localparam int CTRL_CLR_ERR = 3;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_SPURIOUS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RST   = 2'd3
  } state_t;

endpackage

// File: rtl/tick_divider.sv
// Reloadable down-counter producing a one-cycle tick every div+1 cycles.
// While held it parks at terminal count so a deferred tick fires as soon as hold drops.
module tick_divider
  import wavegen_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] div,
  input  logic         hold,
  input  logic         load,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == '0) && !hold && !load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (!hold) begin
      cnt <= div;
    end
  end

endmodule

// File: rtl/twoblock_ctrl.sv
// Sequencer/config controller for the two-channel wave datapath: shadow-to-live commit,
// sample strobe pacing, in-flight tracking with timeout, and datapath resync reset.
module twoblock_ctrl
  import wavegen_pkg::*;
#(
  parameter int MAX_OUT    = 8,
  parameter int TIMEOUT    = 64,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CH_W-1:0]   wr_data,
  input  logic              activeout,
  output logic [CH_W-1:0]   amps,
  output logic [CH_W-1:0]   offsets,
  output logic [CH_W-1:0]   phasewords,
  output logic              activein,
  output logic              dp_reset,
  output logic              busy,
  output logic [ERR_W-1:0]  err,
  output logic [CH_W-1:0]   sample_count
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  state_t state, state_nxt;

  logic [CH_W-1:0]  sh_amps, sh_offsets, sh_phase;
  logic [DIV_W-1:0] div;
  logic             enable, enable_nxt, resync_flag;
  logic [OW-1:0]    outstanding;
  logic [TW-1:0]    tcnt;
  logic [RW-1:0]    rcnt;

  logic ctrl_wr, do_commit, do_resync, do_clr;
  logic div_load, div_hold, load_live, tick;
  logic accepted, spurious, timeout;

  assign ctrl_wr    = wr_en && (wr_addr == ADDR_CTRL);
  assign do_commit  = ctrl_wr && wr_data[CTRL_COMMIT];
  assign do_resync  = ctrl_wr && wr_data[CTRL_RESYNC];
  assign do_clr     = ctrl_wr && wr_data[CTRL_CLR_ERR];
  assign enable_nxt = ctrl_wr ? wr_data[CTRL_ENABLE] : enable;

  assign accepted = activeout && (outstanding != '0);
  assign spurious = activeout && (outstanding == '0);
  assign timeout  = (outstanding != '0) && !activeout && (tcnt == TW'(TIMEOUT - 1));

  tick_divider #(.W(DIV_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .div   (div),
    .hold  (div_hold),
    .load  (div_load),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (do_commit || do_resync) state_nxt = DRAIN;
        else if (enable_nxt)        state_nxt = RUN;
      end
      RUN: begin
        if (do_commit || do_resync) state_nxt = DRAIN;
        else if (!enable_nxt)       state_nxt = IDLE;
      end
      DRAIN: begin
        if (outstanding == '0) begin
          if (resync_flag || do_resync) state_nxt = RST;
          else                          state_nxt = enable_nxt ? RUN : IDLE;
        end
      end
      RST: begin
        if (rcnt == '0) state_nxt = enable_nxt ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A tick that would land on a state change or a full in-flight window waits at terminal count.
  always_comb begin
    div_load  = 1'b0;
    div_hold  = 1'b1;
    load_live = 1'b0;
    case (state)
      IDLE:    div_load  = 1'b1;
      RUN:     div_hold  = (state_nxt != RUN) || (outstanding == OW'(MAX_OUT));
      DRAIN:   load_live = (outstanding == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_amps     <= '0;
      sh_offsets  <= '0;
      sh_phase    <= '0;
      div         <= '0;
      enable      <= 1'b0;
      resync_flag <= 1'b0;
    end else begin
      enable <= enable_nxt;
      if (wr_en) begin
        case (wr_addr)
          ADDR_AMPS:    sh_amps    <= wr_data;
          ADDR_OFFSETS: sh_offsets <= wr_data;
          ADDR_PHASE:   sh_phase   <= wr_data;
          ADDR_DIV:     div        <= wr_data[DIV_W-1:0];
          default:      ;
        endcase
      end
      if (state_nxt != DRAIN)                         resync_flag <= 1'b0;
      else if (do_resync && state != RST)             resync_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      amps       <= '0;
      offsets    <= '0;
      phasewords <= '0;
    end else if (load_live) begin
      amps       <= sh_amps;
      offsets    <= sh_offsets;
      phasewords <= sh_phase;
    end
  end

  // A timeout abandons every in-flight sample; only a strobe issued this cycle survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding  <= '0;
      tcnt         <= '0;
      sample_count <= '0;
      err          <= '0;
      activein     <= 1'b0;
    end else begin
      activein <= tick;
      if (timeout)               outstanding <= tick ? OW'(1) : '0;
      else if (tick && !accepted) outstanding <= outstanding + 1'b1;
      else if (!tick && accepted) outstanding <= outstanding - 1'b1;
      if (outstanding == '0 || activeout || timeout) tcnt <= '0;
      else                                           tcnt <= tcnt + 1'b1;
      if (accepted) sample_count <= sample_count + 1'b1;
      err <= (do_clr ? '0 : err) | {spurious, timeout};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt     <= '0;
      dp_reset <= 1'b1;
      busy     <= 1'b0;
    end else begin
      if (state_nxt == RST && state != RST) rcnt <= RW'(RST_CYCLES - 1);
      else if (state == RST && rcnt != '0)  rcnt <= rcnt - 1'b1;
      dp_reset <= (state_nxt == RST);
      busy     <= (state_nxt == DRAIN) || (state_nxt == RST);
    end
  end

endmodule

// File: tb/tb_twoblock_ctrl.sv
// Scoreboard bench for twoblock_ctrl: a behavioural datapath returns samples, a monitor
// checks live loads, sample counts and errors against a high-level model.
module tb_twoblock_ctrl;
  import wavegen_pkg::*;

  localparam int MAX_OUT    = 8;
  localparam int TIMEOUT    = 64;
  localparam int RST_CYCLES = 4;
  localparam int RET_DELAY  = 5;

  logic        clk = 1'b0;
  logic        reset, wr_en, activeout;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] amps, offsets, phasewords, sample_count;
  logic        activein, dp_reset, busy;
  logic [1:0]  err;

  twoblock_ctrl #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .activeout    (activeout),
    .amps         (amps),
    .offsets      (offsets),
    .phasewords   (phasewords),
    .activein     (activein),
    .dp_reset     (dp_reset),
    .busy         (busy),
    .err          (err),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [95:0] expLive[$];
  logic [31:0] expCount[$];
  logic [31:0] shAmps = '0, shOff = '0, shPh = '0;
  int          inflight = 0, idleCycles = 0, prevInflight = 0;
  logic [1:0]  expErr = '0, prevExp = '0, prevErr = '0;
  logic [31:0] modelCount = '0, prevCount = '0;
  logic [95:0] prevLive = '0;
  bit          stall = 0, spurReq = 0;
  int          dpCyc = 0;
  int          retQ[$];

  task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got no event want event within bound", name);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (a == ADDR_AMPS)    shAmps = d;
    if (a == ADDR_OFFSETS) shOff  = d;
    if (a == ADDR_PHASE)   shPh   = d;
    if (a == ADDR_CTRL && (d[CTRL_COMMIT] || d[CTRL_RESYNC]))
      expLive.push_back({shAmps, shOff, shPh});
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic waitActivein(input int bound, output int waited, output bit ok);
    waited = 0; ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk); #1;
      waited++;
      if (activein) ok = 1;
    end
  endtask

  // Behavioural datapath: every strobe comes back RET_DELAY cycles later unless stalled.
  initial begin
    activeout = 1'b0;
    forever begin
      @(posedge clk); #2;
      dpCyc++;
      if (reset) begin
        retQ.delete();
        activeout = 1'b0;
      end else begin
        if (activein && !stall) retQ.push_back(dpCyc + RET_DELAY);
        activeout = 1'b0;
        if (retQ.size() > 0 && retQ[0] == dpCyc) begin
          void'(retQ.pop_front());
          activeout = 1'b1;
        end else if (spurReq) begin
          activeout = 1'b1;
          spurReq = 0;
        end
      end
    end
  end

  // Monitor: compare what the DUT shows now, then fold this cycle's inputs into the model.
  initial begin
    logic [95:0] w;
    bit spur, tmo;
    forever begin
      @(negedge clk);
      if (reset) begin
        expLive.delete(); expCount.delete();
        inflight = 0; idleCycles = 0; prevInflight = 0;
        expErr = '0; prevExp = '0; prevErr = '0;
        modelCount = '0; prevCount = '0; prevLive = '0;
      end else begin
        if ({amps, offsets, phasewords} !== prevLive) begin
          if (expLive.size() == 0) failNow("live_unexpected");
          else begin
            w = expLive.pop_front();
            checkOutput("live_value", {amps, offsets, phasewords}, w);
          end
          checkOutput("live_after_drain", 96'(prevInflight), 96'd0);
        end
        if (sample_count !== prevCount) begin
          if (expCount.size() == 0) failNow("count_unexpected");
          else begin
            w = 96'(expCount.pop_front());
            checkOutput("sample_count", 96'(sample_count), w);
          end
        end
        if (err !== prevErr || expErr !== prevExp) checkOutput("err", 96'(err), 96'(expErr));
        if (activein) checkOutput("activein_not_busy", 96'(busy), 96'd0);
        prevLive  = {amps, offsets, phasewords};
        prevCount = sample_count;
        prevErr   = err;
        prevExp   = expErr;

        spur = 0; tmo = 0;
        if (activein) inflight++;
        if (activeout) begin
          if (inflight > 0) begin
            inflight--;
            modelCount++;
            expCount.push_back(modelCount);
          end else spur = 1;
        end
        if (inflight > 0 && !activeout) begin
          idleCycles++;
          if (idleCycles == TIMEOUT) begin
            tmo = 1; inflight = 0; idleCycles = 0;
          end
        end else idleCycles = 0;
        if (wr_en && wr_addr == ADDR_CTRL && wr_data[CTRL_CLR_ERR]) expErr = '0;
        expErr = expErr | {spur, tmo};
        prevInflight = inflight;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, n;
    bit ok;
    logic [31:0] cnt;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_amps", 96'(amps), 96'd0);
    checkOutput("reset_count", 96'(sample_count), 96'd0);
    checkOutput("reset_dp_reset", 96'(dp_reset), 96'd1);
    checkOutput("reset_busy", 96'({busy, activein, err}), 96'd0);
    @(negedge clk); reset = 1'b0;
    #1 checkOutput("dp_reset_hold", 96'(dp_reset), 96'd1);
    @(posedge clk); #1;
    checkOutput("dp_reset_fall", 96'(dp_reset), 96'd0);

    $display("[TB] divider period");
    applyStimulus(ADDR_DIV, 32'd3);
    applyStimulus(ADDR_CTRL, 32'h1);
    waitActivein(20, w, ok);
    if (!ok) failNow("first_activein");
    for (int k = 0; k < 3; k++) begin
      waitActivein(10, w, ok);
      checkOutput("activein_period", 96'(w), 96'd4);
    end

    $display("[TB] commits under traffic");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(ADDR_AMPS, (k == 0) ? 32'h40002000 : $urandom());
      applyStimulus(ADDR_OFFSETS, $urandom());
      applyStimulus(ADDR_PHASE, $urandom());
      waitCycles($urandom_range(2, 6));
      applyStimulus(ADDR_CTRL, 32'h3);
      checkOutput("busy_after_commit", 96'(busy), 96'd1);
      n = 0;
      while (busy && n < 30) begin waitCycles(1); n++; end
      if (busy) failNow("commit_done");
      checkOutput("commit_amps", 96'(amps), 96'(shAmps));
      applyStimulus(ADDR_DIV, 32'($urandom_range(0, 4)));
      waitCycles(8);
    end

    $display("[TB] timeout");
    applyStimulus(ADDR_CTRL, 32'h0);
    waitCycles(10);
    stall = 1;
    applyStimulus(ADDR_DIV, 32'd20);
    applyStimulus(ADDR_CTRL, 32'h1);
    waitActivein(40, w, ok);
    if (!ok) failNow("stall_activein");
    applyStimulus(ADDR_CTRL, 32'h0);
    waitCycles(TIMEOUT - 2);
    checkOutput("err_before_timeout", 96'(err[ERR_TIMEOUT]), 96'd0);
    waitCycles(1);
    checkOutput("err_timeout", 96'(err[ERR_TIMEOUT]), 96'd1);
    stall = 0;
    applyStimulus(ADDR_CTRL, 32'h8);
    checkOutput("clr_err", 96'(err), 96'd0);

    $display("[TB] spurious return");
    cnt = sample_count;
    spurReq = 1;
    waitCycles(3);
    checkOutput("spur_err", 96'(err[ERR_SPURIOUS]), 96'd1);
    checkOutput("spur_count", 96'(sample_count), 96'(cnt));
    applyStimulus(ADDR_CTRL, 32'h8);

    $display("[TB] commit with resync");
    applyStimulus(ADDR_DIV, 32'($urandom_range(0, 4)));
    applyStimulus(ADDR_AMPS, $urandom());
    applyStimulus(ADDR_OFFSETS, $urandom());
    applyStimulus(ADDR_PHASE, $urandom());
    applyStimulus(ADDR_CTRL, 32'h1);
    waitCycles(12);
    applyStimulus(ADDR_CTRL, 32'h7);
    n = 0;
    while (!dp_reset && n < 40) begin waitCycles(1); n++; end
    if (!dp_reset) failNow("resync_dp_reset");
    checkOutput("live_before_rst", {amps, offsets, phasewords}, {shAmps, shOff, shPh});
    n = 0;
    while (dp_reset && n < 20) begin waitCycles(1); n++; end
    checkOutput("rst_len", 96'(n), 96'(RST_CYCLES));
    checkOutput("busy_after_rst", 96'(busy), 96'd0);
    checkOutput("no_activein_at_fall", 96'(activein), 96'd0);
    waitActivein(10, w, ok);
    if (!ok) failNow("activein_resume");
    waitCycles(10);
    checkOutput("sb_live_drained", 96'(expLive.size()), 96'd0);

    $display("[TB] in-flight limit and reset in drain");
    applyStimulus(ADDR_CTRL, 32'h0);
    waitCycles(10);
    stall = 1;
    applyStimulus(ADDR_DIV, 32'd0);
    applyStimulus(ADDR_CTRL, 32'h1);
    n = 0;
    for (int i = 0; i < 30; i++) begin waitCycles(1); if (activein) n++; end
    checkOutput("max_out_pulses", 96'(n), 96'(MAX_OUT));
    spurReq = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin waitCycles(1); if (activein) n++; end
    checkOutput("deferred_resume", 96'(n), 96'd1);
    applyStimulus(ADDR_CTRL, 32'h3);
    waitCycles(2);
    checkOutput("drain_busy", 96'(busy), 96'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_live", {amps, offsets, phasewords}, 96'd0);
    checkOutput("async_count", 96'(sample_count), 96'd0);
    checkOutput("async_flags", 96'({dp_reset, busy, activein, err}), 96'b10000);
    @(negedge clk); reset = 1'b0;
    stall = 0;
    waitCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
